// File: rtl/pipe_stall_ctrl.sv
// Stall/retire controller: one miss-penalty FSM per memory port feeding stage
// write enables, load-use bubble, retire/stall counters and sticky halt/error flags.
module pipe_stall_port #(
  parameter int MISS_LATENCY = 5,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic is_hit,
  input  logic is_miss,
  input  logic accept,
  output logic busy,
  output logic fill_done,
  output logic err
);
  typedef enum logic {S_IDLE, S_MISS} state_t;

  localparam logic [CNT_W-1:0] LAT    = CNT_W'(MISS_LATENCY);
  localparam bit               LAT_EN = (MISS_LATENCY > 0);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    err         = (is_hit | is_miss) & ~req;
    case (r_state)
      S_IDLE: begin
        // hit+miss together is resolved as a miss but still flagged
        err = err | (req & is_hit & is_miss);
        if (req && is_miss && accept && LAT_EN) begin
          w_state_nxt = S_MISS;
          w_cnt_nxt   = LAT;
        end
      end
      S_MISS: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_MISS);
  assign fill_done = busy && (r_cnt == CNT_W'(1));
endmodule

module pipe_stall_ctrl #(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_PORTS    = 2,
  parameter int MISS_LATENCY = 5,
  parameter int CNT_W        = 4,
  parameter int NUM_STAGES   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [NUM_PORTS-1:0]  is_hit,
  input  logic [NUM_PORTS-1:0]  is_miss,
  input  logic                  hazard_stall,
  input  logic                  retire_valid,
  input  logic                  halt_req,
  output logic                  stall,
  output logic [NUM_PORTS-1:0]  port_busy,
  output logic [NUM_PORTS-1:0]  fill_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  bubble,
  output logic [WORD_SIZE-1:0]  num_inst,
  output logic [WORD_SIZE-1:0]  stall_cycles,
  output logic                  is_halted,
  output logic                  proto_err
);
  logic [NUM_PORTS-1:0] w_err;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    pipe_stall_port #(.MISS_LATENCY(MISS_LATENCY), .CNT_W(CNT_W)) u_port (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req[p]),
      .is_hit    (is_hit[p]),
      .is_miss   (is_miss[p]),
      .accept    (~is_halted),
      .busy      (port_busy[p]),
      .fill_done (fill_done[p]),
      .err       (w_err[p])
    );
  end

  assign stall = |port_busy;

  always_comb begin
    stage_en = '1;
    bubble   = 1'b0;
    if (is_halted || stall) begin
      stage_en = '0;
    end else if (hazard_stall) begin
      stage_en[1:0] = 2'b00;
      bubble        = 1'b1;
    end
  end

  // halt only lands once the pipe is unfrozen, so the halting retire is counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst     <= '0;
      stall_cycles <= '0;
      is_halted    <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (retire_valid && !stall && !is_halted) num_inst <= num_inst + 1'b1;
      if (stall && !(&stall_cycles))            stall_cycles <= stall_cycles + 1'b1;
      if (halt_req && !stall)                   is_halted <= 1'b1;
      if (|w_err)                               proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a timeline model pushes expected outputs
// per driven cycle; they are popped and compared just after the clock edge.
module tb_pipe_stall_ctrl;
  localparam int LAT = 5;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  req = '0, is_hit = '0, is_miss = '0;
  logic        hazard_stall = 1'b0, retire_valid = 1'b0, halt_req = 1'b0;
  logic        stall, bubble, is_halted, proto_err;
  logic [1:0]  port_busy, fill_done;
  logic [4:0]  stage_en;
  logic [15:0] num_inst, stall_cycles;

  pipe_stall_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req(req), .is_hit(is_hit), .is_miss(is_miss),
    .hazard_stall(hazard_stall), .retire_valid(retire_valid), .halt_req(halt_req),
    .stall(stall), .port_busy(port_busy), .fill_done(fill_done), .stage_en(stage_en),
    .bubble(bubble), .num_inst(num_inst), .stall_cycles(stall_cycles),
    .is_halted(is_halted), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  busy, fill;
    logic        stall, bub, halt, err;
    logic [4:0]  en;
    logic [15:0] num, stc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_err = 0;
  int          m_left[2];
  logic [15:0] m_num, m_stc;
  logic        m_halt, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_left[0] = 0; m_left[1] = 0;
    m_num = '0; m_stc = '0; m_halt = 1'b0; m_err = 1'b0;
    sb.delete();
  endtask

  // asynchronous reset pulse between edges; outputs must clear with no clock
  task automatic do_reset();
    req = '0; is_hit = '0; is_miss = '0;
    hazard_stall = 0; retire_valid = 0; halt_req = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", port_busy, 0);
    chk("rst_fill", fill_done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_en", stage_en, 5'b11111);
    chk("rst_bubble", bubble, 0);
    chk("rst_num", num_inst, 0);
    chk("rst_stc", stall_cycles, 0);
    chk("rst_halt", is_halted, 0);
    chk("rst_err", proto_err, 0);
    #1 reset_n = 1'b1;
    model_clear();
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] ht, input logic [1:0] ms,
                      input logic hz, input logic rv, input logic hr);
    exp_t e, g;
    logic pre_stall;
    req = rq; is_hit = ht; is_miss = ms;
    hazard_stall = hz; retire_valid = rv; halt_req = hr;
    pre_stall = (m_left[0] > 0) || (m_left[1] > 0);
    if (rv && !pre_stall && !m_halt) m_num = m_num + 16'd1;
    if (pre_stall && m_stc != 16'hFFFF) m_stc = m_stc + 16'd1;
    for (int p = 0; p < 2; p++) begin
      if ((ht[p] | ms[p]) && !rq[p]) m_err = 1'b1;
      if (m_left[p] > 0) m_left[p]--;
      else begin
        if (rq[p] && ht[p] && ms[p]) m_err = 1'b1;
        if (rq[p] && ms[p] && !m_halt) m_left[p] = LAT;
      end
    end
    if (hr && !pre_stall) m_halt = 1'b1;
    for (int p = 0; p < 2; p++) begin
      e.busy[p] = (m_left[p] > 0);
      e.fill[p] = (m_left[p] == 1);
    end
    e.stall = |e.busy;
    e.en    = (m_halt || e.stall) ? 5'b00000 : (hz ? 5'b11100 : 5'b11111);
    e.bub   = !m_halt && !e.stall && hz;
    e.num = m_num; e.stc = m_stc; e.halt = m_halt; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("busy", port_busy, g.busy);
    chk("fill_done", fill_done, g.fill);
    chk("stall", stall, g.stall);
    chk("stage_en", stage_en, g.en);
    chk("bubble", bubble, g.bub);
    chk("num_inst", num_inst, g.num);
    chk("stall_cycles", stall_cycles, g.stc);
    chk("is_halted", is_halted, g.halt);
    chk("proto_err", proto_err, g.err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    #1 do_reset();

    // single data-port miss
    idle(2);
    step(2'b10, 2'b00, 2'b10, 0, 0, 0);
    idle(7);
    chk("s1_stc", stall_cycles, 5);
    chk("s1_en", stage_en, 5'b11111);

    // overlapping misses stall for the union only
    do_reset();
    step(2'b01, 2'b00, 2'b01, 0, 0, 0);
    idle(1);
    step(2'b10, 2'b00, 2'b10, 0, 0, 0);
    idle(9);
    chk("s2_stc", stall_cycles, 7);

    // retires across a miss are counted once each
    do_reset();
    for (int i = 0; i < 10; i++)
      step((i == 2) ? 2'b10 : 2'b00, 2'b00, (i == 2) ? 2'b10 : 2'b00, 0, 1, 0);
    idle(1);
    chk("s3_num", num_inst, 5);

    // load-use bubble, then hazard overlapped with a miss
    step(2'b00, 2'b00, 2'b00, 1, 0, 0);
    chk("s4_en_hz", stage_en, 5'b11100);
    chk("s4_bub_hz", bubble, 1);
    step(2'b01, 2'b00, 2'b01, 1, 0, 0);
    chk("s4_en_miss", stage_en, 5'b00000);
    chk("s4_bub_miss", bubble, 0);
    idle(6);

    // retire counter wrap, and hit+miss treated as miss with error flag
    do_reset();
    for (int i = 0; i < 65535; i++) step(2'b00, 2'b00, 2'b00, 0, 1, 0);
    chk("s5_full", num_inst, 16'hFFFF);
    step(2'b00, 2'b00, 2'b00, 0, 1, 0);
    chk("s5_wrap", num_inst, 0);
    step(2'b01, 2'b01, 2'b01, 0, 0, 0);
    chk("s5_err", proto_err, 1);
    chk("s5_busy", port_busy, 2'b01);
    idle(6);
    step(2'b00, 2'b10, 2'b00, 0, 0, 0);

    // halt deferred until the stall clears, then everything freezes
    do_reset();
    step(2'b10, 2'b00, 2'b10, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 2'b00, 0, 1, 1);
    chk("s6_halt_wait", is_halted, 0);
    step(2'b00, 2'b00, 2'b00, 0, 1, 1);
    chk("s6_halt_set", is_halted, 1);
    chk("s6_num_halt", num_inst, 1);
    step(2'b01, 2'b00, 2'b01, 0, 1, 0);
    chk("s6_no_miss", port_busy, 0);
    chk("s6_en", stage_en, 5'b00000);
    chk("s6_num_frozen", num_inst, 1);

    // reset in the middle of a penalty
    do_reset();
    step(2'b01, 2'b00, 2'b01, 0, 0, 0);
    idle(1);
    chk("s7_busy_pre", port_busy, 2'b01);
    do_reset();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
